// File: rtl/cic_frame_ctrl_if.sv
// rtl/cic_frame_ctrl_if.sv - signal bundle between the CIC frame sequencer and its neighbours
//
// Purpose: groups every non-clock/reset signal of cic_frame_ctrl.
// Modports:
//   slave  - the sequencer itself (control, source and CIC result in; CIC drive, frame out)
//   master - the environment (sample source, CIC wrapper, capture/DMA side)
// Signals:
//   start/abort/frame_len/warmup  capture control
//   s_data/s_val                  sample source
//   cic_rst/cic_data/cic_val_in   drive to the CIC decimator
//   cic_dout/cic_val_out          result from the CIC decimator
//   o_data/o_val/o_sof/o_eof      framed output stream
//   busy/done/drop_cnt            status
interface cic_frame_ctrl_if #(
  parameter int Win  = 16,
  parameter int Wout = 16
);
  logic            start;
  logic            abort;
  logic [15:0]     frame_len;
  logic [7:0]      warmup;
  logic [Win-1:0]  s_data;
  logic            s_val;
  logic            cic_rst;
  logic [Win-1:0]  cic_data;
  logic            cic_val_in;
  logic [Wout-1:0] cic_dout;
  logic            cic_val_out;
  logic [Wout-1:0] o_data;
  logic            o_val;
  logic            o_sof;
  logic            o_eof;
  logic            busy;
  logic            done;
  logic [15:0]     drop_cnt;

  modport slave (
    input  start, abort, frame_len, warmup, s_data, s_val, cic_dout, cic_val_out,
    output cic_rst, cic_data, cic_val_in, o_data, o_val, o_sof, o_eof, busy, done, drop_cnt
  );

  modport master (
    output start, abort, frame_len, warmup, s_data, s_val, cic_dout, cic_val_out,
    input  cic_rst, cic_data, cic_val_in, o_data, o_val, o_sof, o_eof, busy, done, drop_cnt
  );
endinterface

// File: rtl/cic_frame_ctrl.sv
// rtl/cic_frame_ctrl.sv - sequencer turning a CIC decimator stream into bounded frames
//
// Purpose: on start, holds the CIC in reset for CLR_CYCLES cycles, then feeds it
// source samples, discards the first `warmup` decimated outputs and forwards
// exactly `frame_len` outputs marked with sof/eof. abort returns to IDLE at once.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   bus  - cic_frame_ctrl_if.slave (control, source, CIC drive/result, framed output, status)
// All outputs are registered; their next values are derived from the next state.
module cic_frame_ctrl #(
  parameter int Win        = 16,
  parameter int Wout       = 16,
  parameter int CLR_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  cic_frame_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, CLEAR, WARMUP, RUN, DONE} state_t;

  localparam logic [7:0] CLR_LAST = 8'(CLR_CYCLES - 1);

  state_t          state_q, state_d;
  logic [7:0]      clr_cnt_q, clr_cnt_d;
  logic [7:0]      warm_q, warm_d;
  logic [15:0]     len_q, len_d;
  logic [15:0]     out_cnt_q, out_cnt_d;
  logic            cic_rst_q, cic_rst_d;
  logic [Win-1:0]  cic_data_q, cic_data_d;
  logic            cic_val_in_q, cic_val_in_d;
  logic [Wout-1:0] o_data_q, o_data_d;
  logic            o_val_q, o_val_d;
  logic            o_sof_q, o_sof_d;
  logic            o_eof_q, o_eof_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;
  logic            feed_d;
  logic            last_out;

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    warm_d     = warm_q;
    len_d      = len_q;
    out_cnt_d  = out_cnt_q;
    o_data_d   = o_data_q;
    o_val_d    = 1'b0;
    o_sof_d    = 1'b0;
    o_eof_d    = 1'b0;
    drop_cnt_d = drop_cnt_q;
    last_out   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort && (bus.frame_len != 16'd0)) begin
          len_d     = bus.frame_len;
          warm_d    = bus.warmup;
          clr_cnt_d = 8'd0;
          out_cnt_d = 16'd0;
          state_d   = CLEAR;
        end
      end
      CLEAR: begin
        if (clr_cnt_q == CLR_LAST) begin
          state_d = (warm_q == 8'd0) ? RUN : WARMUP;
        end else begin
          clr_cnt_d = clr_cnt_q + 8'd1;
        end
      end
      WARMUP: begin
        // Leave on the same edge that consumes the last discarded output so
        // that a back-to-back CIC output is already framed.
        if (bus.cic_val_out) begin
          warm_d = warm_q - 8'd1;
          if (warm_q == 8'd1) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (bus.cic_val_out) begin
          last_out  = (out_cnt_q == len_q - 16'd1);
          o_val_d   = 1'b1;
          o_data_d  = bus.cic_dout;
          o_sof_d   = (out_cnt_q == 16'd0);
          o_eof_d   = last_out;
          out_cnt_d = out_cnt_q + 16'd1;
          if (last_out) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // abort overrides every transition, including a final output in RUN.
    if (bus.abort && (state_q != IDLE)) begin
      state_d = IDLE;
      o_val_d = 1'b0;
      o_sof_d = 1'b0;
      o_eof_d = 1'b0;
    end

    feed_d       = (state_d == WARMUP) || (state_d == RUN);
    cic_rst_d    = !feed_d;
    cic_val_in_d = feed_d && bus.s_val;
    cic_data_d   = feed_d ? bus.s_data : cic_data_q;
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE);

    // A sample is dropped whenever it is not forwarded to the CIC.
    if ((state_q == IDLE) && (state_d == CLEAR)) begin
      drop_cnt_d = 16'd0;
    end else if (bus.s_val && !feed_d && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      clr_cnt_q    <= 8'd0;
      warm_q       <= 8'd0;
      len_q        <= 16'd0;
      out_cnt_q    <= 16'd0;
      cic_rst_q    <= 1'b1;
      cic_data_q   <= '0;
      cic_val_in_q <= 1'b0;
      o_data_q     <= '0;
      o_val_q      <= 1'b0;
      o_sof_q      <= 1'b0;
      o_eof_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      drop_cnt_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      warm_q       <= warm_d;
      len_q        <= len_d;
      out_cnt_q    <= out_cnt_d;
      cic_rst_q    <= cic_rst_d;
      cic_data_q   <= cic_data_d;
      cic_val_in_q <= cic_val_in_d;
      o_data_q     <= o_data_d;
      o_val_q      <= o_val_d;
      o_sof_q      <= o_sof_d;
      o_eof_q      <= o_eof_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign bus.cic_rst    = cic_rst_q;
  assign bus.cic_data   = cic_data_q;
  assign bus.cic_val_in = cic_val_in_q;
  assign bus.o_data     = o_data_q;
  assign bus.o_val      = o_val_q;
  assign bus.o_sof      = o_sof_q;
  assign bus.o_eof      = o_eof_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_cic_frame_ctrl.sv
// tb/tb_cic_frame_ctrl.sv - scoreboard bench for cic_frame_ctrl with an R=4 decimator stand-in
module tb_cic_frame_ctrl;
  localparam int WIN  = 16;
  localparam int WOUT = 16;
  localparam int R    = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cic_frame_ctrl_if #(.Win(WIN), .Wout(WOUT)) bus ();

  cic_frame_ctrl #(.Win(WIN), .Wout(WOUT), .CLR_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // expected {data, sof, eof}
  logic [17:0] sb_q[$];
  int sb_warm    = 0;
  int sb_len     = 0;
  int sb_limit   = 0;
  int abort_at_k = -1;
  int n_oval, n_sof, n_eof, n_done;
  bit feed_en = 1'b0;

  // Boxcar decimator by R standing in for the CIC; it also predicts framed outputs.
  initial begin : cic_model
    int cnt;
    int k;
    logic [15:0] acc;
    logic r, v, abort_clr, sof_e, eof_e;
    logic [15:0] d;
    cnt = 0; k = 0; acc = '0; abort_clr = 1'b0;
    bus.cic_val_out = 1'b0;
    bus.cic_dout    = '0;
    forever begin
      @(negedge clk);
      r = bus.cic_rst; v = bus.cic_val_in; d = bus.cic_data;
      @(posedge clk);
      #1;
      if (abort_clr) begin
        bus.abort = 1'b0;
        abort_clr = 1'b0;
      end
      bus.cic_val_out = 1'b0;
      if (r || !rst) begin
        cnt = 0; acc = '0; k = 0;
      end else if (v) begin
        acc = acc + d;
        cnt++;
        if (cnt == R) begin
          bus.cic_val_out = 1'b1;
          bus.cic_dout    = acc;
          if (k >= sb_warm && (k - sb_warm) < sb_limit) begin
            sof_e = (k == sb_warm);
            eof_e = (k == sb_warm + sb_len - 1);
            sb_q.push_back({acc, sof_e, eof_e});
          end
          if (k == abort_at_k) begin
            bus.abort  = 1'b1;
            abort_clr  = 1'b1;
            abort_at_k = -1;
          end
          k++;
          acc = '0;
          cnt = 0;
        end
      end
    end
  end

  initial begin : source
    forever begin
      @(posedge clk);
      #1;
      if (feed_en) begin
        bus.s_val  = 1'b1;
        bus.s_data = 16'($urandom);
      end
    end
  end

  initial begin : monitor
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.o_val) begin
          n_oval++;
          n_sof += int'(bus.o_sof);
          n_eof += int'(bus.o_eof);
          if (sb_q.size() == 0) begin
            check("unexpected_oval", 32'(1), 32'(0));
          end else begin
            e = sb_q.pop_front();
            check("frame_out", 32'({bus.o_data, bus.o_sof, bus.o_eof}), 32'(e));
          end
        end
        if (bus.done) n_done++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_stats();
    n_oval = 0; n_sof = 0; n_eof = 0; n_done = 0;
    sb_q.delete();
  endtask

  task automatic start_frame(input int len, input int warm);
    sb_len = len; sb_warm = warm; sb_limit = len;
    bus.frame_len = 16'(len);
    bus.warmup    = 8'(warm);
    bus.start     = 1'b1;
    tick(1);
    bus.start     = 1'b0;
  endtask

  task automatic count_clear(input string tag);
    int c;
    c = 0;
    while (bus.busy && bus.cic_rst && c < 50) begin
      tick(1);
      c++;
    end
    check(tag, 32'(c), 32'(4));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int c;
    c = 0;
    while (bus.busy && c < budget) begin
      tick(1);
      c++;
    end
    check(tag, 32'(c >= budget), 32'(0));
  endtask

  initial begin : main
    int c;
    bus.start = 1'b0; bus.abort = 1'b0; bus.frame_len = '0; bus.warmup = '0;
    bus.s_data = '0; bus.s_val = 1'b0;
    clear_stats();
    rst = 1'b0;
    tick(3);
    check("rst_cic_rst", 32'(bus.cic_rst), 32'(1));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_oval", 32'(bus.o_val), 32'(0));
    check("rst_done", 32'(bus.done), 32'(0));
    check("rst_drop", 32'(bus.drop_cnt), 32'(0));
    check("rst_val_in", 32'(bus.cic_val_in), 32'(0));
    rst = 1'b1;
    tick(2);

    // drops while idle, then cleared by an accepted start
    repeat (10) begin
      bus.s_val = 1'b1; tick(1);
      bus.s_val = 1'b0; tick(1);
    end
    check("drop_idle", 32'(bus.drop_cnt), 32'(10));

    // normal frame: frame_len=8, warmup=3
    clear_stats();
    start_frame(8, 3);
    check("drop_after_start", 32'(bus.drop_cnt), 32'(0));
    check("busy_after_start", 32'(bus.busy), 32'(1));
    feed_en = 1'b1;
    count_clear("clear_cycles_n");
    wait_idle("frame_n_timeout", 400);
    tick(2);
    check("frame_n_oval", 32'(n_oval), 32'(8));
    check("frame_n_sof", 32'(n_sof), 32'(1));
    check("frame_n_eof", 32'(n_eof), 32'(1));
    check("frame_n_done", 32'(n_done), 32'(1));
    check("frame_n_sb_empty", 32'(sb_q.size()), 32'(0));
    check("frame_n_cic_rst", 32'(bus.cic_rst), 32'(1));

    // warmup=0, frame_len=1
    clear_stats();
    start_frame(1, 0);
    count_clear("clear_cycles_1");
    wait_idle("frame_1_timeout", 200);
    tick(2);
    check("frame_1_oval", 32'(n_oval), 32'(1));
    check("frame_1_sof", 32'(n_sof), 32'(1));
    check("frame_1_eof", 32'(n_eof), 32'(1));
    check("frame_1_done", 32'(n_done), 32'(1));

    // abort on the 5th RUN output
    clear_stats();
    start_frame(8, 3);
    sb_limit   = 4;
    abort_at_k = 3 + 4;
    c = 0;
    while (!bus.abort && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("abort_seen_timeout", 32'(c >= 2000), 32'(0));
    @(posedge clk);
    #2;
    check("abort_busy", 32'(bus.busy), 32'(0));
    check("abort_val_in", 32'(bus.cic_val_in), 32'(0));
    check("abort_cic_rst", 32'(bus.cic_rst), 32'(1));
    #1;
    tick(20);
    check("abort_oval", 32'(n_oval), 32'(4));
    check("abort_eof", 32'(n_eof), 32'(0));
    check("abort_done", 32'(n_done), 32'(0));
    check("abort_sb_empty", 32'(sb_q.size()), 32'(0));

    // start with frame_len=0 is ignored
    clear_stats();
    bus.frame_len = 16'd0;
    bus.warmup    = 8'd2;
    bus.start     = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(2);
    check("len0_busy", 32'(bus.busy), 32'(0));
    check("len0_cic_rst", 32'(bus.cic_rst), 32'(1));
    check("len0_done", 32'(n_done), 32'(0));

    // drop counter saturation
    feed_en = 1'b0;
    tick(1);
    bus.s_val = 1'b1;
    tick(70000);
    bus.s_val = 1'b0;
    tick(1);
    check("drop_saturate", 32'(bus.drop_cnt), 32'(16'hFFFF));

    // asynchronous reset in the middle of RUN
    clear_stats();
    feed_en = 1'b1;
    start_frame(8, 3);
    c = 0;
    while (n_oval < 2 && c < 400) begin
      tick(1);
      c++;
    end
    check("mid_run_timeout", 32'(c >= 400), 32'(0));
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_cic_rst", 32'(bus.cic_rst), 32'(1));
    check("arst_oval", 32'(bus.o_val), 32'(0));
    check("arst_busy", 32'(bus.busy), 32'(0));
    check("arst_done", 32'(bus.done), 32'(0));
    check("arst_drop", 32'(bus.drop_cnt), 32'(0));
    feed_en = 1'b0;
    bus.s_val = 1'b0;
    tick(3);
    sb_q.delete();
    rst = 1'b1;
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
